// File: rtl/fb_sched_pkg.sv
// fb_sched_pkg: state type, client count and default widths shared by the
// framebuffer draw scheduler and its clear generator.
package fb_sched_pkg;
    typedef enum logic [2:0] {IDLE, SWAP, CLEAR, DRAW0, DRAW1} fb_sched_state_t;
    localparam int NCLIENT = 2;
    localparam int OVR_W = 8;
    localparam int DEF_FB_ADDRW = 16;
    localparam int DEF_FB_DATAW = 4;
endpackage

// File: rtl/fb_clear_gen.sv
// fb_clear_gen: back-buffer clear address counter; start rewinds to 0, step
// advances, last flags the final pixel address.
module fb_clear_gen #(
    parameter int FB_PIXELS = 57600,
    parameter int FB_ADDRW = 16
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic                start,
    input  logic                step,
    output logic [FB_ADDRW-1:0] addr,
    output logic                last
);
    assign last = addr == FB_ADDRW'(FB_PIXELS - 1);
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n)
            addr <= '0;
        else
            addr <= start ? '0 : step ? addr + 1'b1 : addr;
    end
endmodule

// File: rtl/fb_draw_sched.sv
// fb_draw_sched: double-buffer frame sequencer and framebuffer write arbiter.
// Define FB_DRAW_SCHED_TIMEOUT_EN to enable the draw-phase watchdog.
module fb_draw_sched
    import fb_sched_pkg::*;
#(
    parameter int FB_PIXELS = 57600,
    parameter int FB_ADDRW = DEF_FB_ADDRW,
    parameter int FB_DATAW = DEF_FB_DATAW,
    parameter int CLEAR_COLR = 0,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic                frame_sys,
    input  logic                enable,
    output logic [NCLIENT-1:0]  r_start,
    input  logic [NCLIENT-1:0]  r_done,
    input  logic [NCLIENT-1:0]  r_we,
    input  logic [FB_ADDRW-1:0] r_addr0,
    input  logic [FB_ADDRW-1:0] r_addr1,
    input  logic [FB_DATAW-1:0] r_colr0,
    input  logic [FB_DATAW-1:0] r_colr1,
    output logic                fb_we,
    output logic [FB_ADDRW-1:0] fb_addr,
    output logic [FB_DATAW-1:0] fb_colr,
    output logic                fb_sel,
    output logic                busy,
    output logic [OVR_W-1:0]    overrun_cnt,
    output logic                timeout
);
    fb_sched_state_t state;
    logic [FB_ADDRW-1:0] clr_addr;
    logic clr_last, go, d0, d1, adv0, adv1, ovr_hit, to_hit;

    fb_clear_gen #(.FB_PIXELS(FB_PIXELS), .FB_ADDRW(FB_ADDRW)) u_clear (
        .clk_sys(clk_sys),
        .rst_sys_n(rst_sys_n),
        .start(state == SWAP),
        .step(state == CLEAR),
        .addr(clr_addr),
        .last(clr_last)
    );

    assign busy = state != IDLE;
    assign go = frame_sys && enable;
    // a done coinciding with its own start pulse is ignored
    assign d0 = state == DRAW0 && r_done[0] && !r_start[0];
    assign d1 = state == DRAW1 && r_done[1] && !r_start[1];
    assign adv0 = d0 || (state == DRAW0 && to_hit);
    assign adv1 = d1 || (state == DRAW1 && to_hit);
    assign ovr_hit = frame_sys && state != IDLE && !(adv1 && enable);

`ifdef FB_DRAW_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    assign to_hit = to_cnt == TO_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            to_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            to_cnt <= (state == DRAW0 || state == DRAW1) && !adv0 && !adv1 ? to_cnt + 1'b1 : '0;
            timeout <= timeout || (adv0 && !d0) || (adv1 && !d1);
        end
    end
`else
    assign to_hit = 1'b0;
    assign timeout = TIMEOUT_CYC < 0;
`endif

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state <= IDLE;
            fb_sel <= 1'b0;
            fb_we <= 1'b0;
            fb_addr <= '0;
            fb_colr <= '0;
            r_start <= '0;
            overrun_cnt <= '0;
        end else begin
            r_start <= '0;
            case (state)
                IDLE: state <= go ? SWAP : IDLE;
                SWAP: begin
                    fb_sel <= !fb_sel;
                    state <= CLEAR;
                end
                CLEAR: if (clr_last) begin
                    state <= DRAW0;
                    r_start <= 2'b01;
                end
                DRAW0: if (adv0) begin
                    state <= DRAW1;
                    r_start <= 2'b10;
                end
                DRAW1: if (adv1) state <= go ? SWAP : IDLE;
                default: state <= IDLE;
            endcase
            fb_we <= state == CLEAR || (state == DRAW0 && r_we[0]) || (state == DRAW1 && r_we[1]);
            fb_addr <= state == CLEAR ? clr_addr : state == DRAW1 ? r_addr1 : r_addr0;
            fb_colr <= state == CLEAR ? FB_DATAW'(CLEAR_COLR) : state == DRAW1 ? r_colr1 : r_colr0;
            if (ovr_hit && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end
endmodule
